// File: rtl/pong_pkg.sv
// Shared game-controller types and defaults: state encoding, score width and
// the match/serve parameter defaults used by game_fsm_ctrl.
package pong_pkg;

    localparam int unsigned SCORE_W         = 4;
    localparam int unsigned TICK_W          = 8;
    localparam int unsigned WIN_SCORE_DEF   = 7;
    localparam int unsigned SERVE_TICKS_DEF = 60;

    typedef enum logic [2:0] {
        MENU     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        PAUSE    = 3'd3,
        GAMEOVER = 3'd4
    } game_state_e;

    // Increment that never passes the limit, so scores cannot wrap.
    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] v,
        input logic [SCORE_W-1:0] lim
    );
        return (v >= lim) ? lim : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus rising-edge pulse for one raw button.
// Edges are suppressed until the synchronizer holds a real sample, so a button
// already held when reset is released never produces a pulse.
module btn_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [1:0] r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_valid <= 2'b00;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_valid <= {r_valid[0], 1'b1};
            // Until r_sync2 is valid, treat the button as "previously high".
            r_prev  <= r_sync2 | ~r_valid[1];
        end
    end

    assign o_pulse = r_valid[1] & r_sync2 & ~r_prev;

endmodule

// File: rtl/game_fsm_ctrl.sv
// Pong game-flow controller: menu, serve delay, scoring and game-over.
// Optional PLAY<->PAUSE toggle is built only when GAME_PAUSE_EN is defined.
module game_fsm_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
    parameter int unsigned SERVE_TICKS = SERVE_TICKS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               animate,
    input  logic               p1_up,
    input  logic               p1_down,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               p1_scored,
    input  logic               p2_scored,
    output logic [2:0]         state,
    output logic               menu_sel,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               ball_reset,
    output logic               ball_run,
    output logic               winner
);

    localparam logic [SCORE_W-1:0] WIN_L   = SCORE_W'(WIN_SCORE);
    localparam logic [TICK_W-1:0]  TICKS_L = TICK_W'(SERVE_TICKS);

    logic w_up, w_down, w_start, w_pause;

    btn_edge u_edge_up    (.i_clk(clk), .i_rst_n(rst_n), .i_btn(p1_up),     .o_pulse(w_up));
    btn_edge u_edge_down  (.i_clk(clk), .i_rst_n(rst_n), .i_btn(p1_down),   .o_pulse(w_down));
    btn_edge u_edge_start (.i_clk(clk), .i_rst_n(rst_n), .i_btn(btn_start), .o_pulse(w_start));
`ifdef GAME_PAUSE_EN
    btn_edge u_edge_pause (.i_clk(clk), .i_rst_n(rst_n), .i_btn(btn_pause), .o_pulse(w_pause));
`else
    logic w_unused_pause;
    assign w_unused_pause = btn_pause;
    assign w_pause        = 1'b0;
`endif

    game_state_e        r_state, w_state_nxt;
    logic               r_menu_sel, w_menu_nxt;
    logic [SCORE_W-1:0] r_s1, w_s1_nxt, w_s1_inc;
    logic [SCORE_W-1:0] r_s2, w_s2_nxt, w_s2_inc;
    logic               r_ball_reset, w_ball_reset_nxt;
    logic               r_ball_run, w_ball_run_nxt;
    logic               r_winner, w_winner_nxt;
    logic [TICK_W-1:0]  r_tick, w_tick_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= MENU;
            r_menu_sel   <= 1'b0;
            r_s1         <= '0;
            r_s2         <= '0;
            r_ball_reset <= 1'b0;
            r_ball_run   <= 1'b0;
            r_winner     <= 1'b0;
            r_tick       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_menu_sel   <= w_menu_nxt;
            r_s1         <= w_s1_nxt;
            r_s2         <= w_s2_nxt;
            r_ball_reset <= w_ball_reset_nxt;
            r_ball_run   <= w_ball_run_nxt;
            r_winner     <= w_winner_nxt;
            r_tick       <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_menu_nxt       = r_menu_sel;
        w_s1_nxt         = r_s1;
        w_s2_nxt         = r_s2;
        w_ball_reset_nxt = 1'b0;
        w_winner_nxt     = r_winner;
        w_tick_nxt       = r_tick;
        w_s1_inc         = sat_inc(r_s1, WIN_L);
        w_s2_inc         = sat_inc(r_s2, WIN_L);

        case (r_state)
            MENU: begin
                if (w_up && !w_down) begin
                    w_menu_nxt = 1'b1;
                end else if (w_down && !w_up) begin
                    w_menu_nxt = 1'b0;
                end
                if (w_start) begin
                    w_state_nxt      = SERVE;
                    w_s1_nxt         = '0;
                    w_s2_nxt         = '0;
                    w_tick_nxt       = '0;
                    w_ball_reset_nxt = 1'b1;
                end
            end
            SERVE: begin
                if (animate) begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                    if (r_tick + TICK_W'(1) == TICKS_L) begin
                        w_state_nxt = PLAY;
                    end
                end
            end
            PLAY: begin
                // P1 wins ties: a simultaneous P2 pulse is dropped.
                if (p1_scored) begin
                    w_s1_nxt = w_s1_inc;
                    if (w_s1_inc == WIN_L) begin
                        w_state_nxt  = GAMEOVER;
                        w_winner_nxt = 1'b0;
                    end else begin
                        w_state_nxt      = SERVE;
                        w_tick_nxt       = '0;
                        w_ball_reset_nxt = 1'b1;
                    end
                end else if (p2_scored) begin
                    w_s2_nxt = w_s2_inc;
                    if (w_s2_inc == WIN_L) begin
                        w_state_nxt  = GAMEOVER;
                        w_winner_nxt = 1'b1;
                    end else begin
                        w_state_nxt      = SERVE;
                        w_tick_nxt       = '0;
                        w_ball_reset_nxt = 1'b1;
                    end
                end else if (w_pause) begin
                    w_state_nxt = PAUSE;
                end
            end
`ifdef GAME_PAUSE_EN
            PAUSE: begin
                if (w_pause) begin
                    w_state_nxt = PLAY;
                end
            end
`endif
            GAMEOVER: begin
                if (w_start) begin
                    w_state_nxt = MENU;
                end
            end
            default: begin
                w_state_nxt = MENU;
            end
        endcase

        w_ball_run_nxt = (w_state_nxt == PLAY);
    end

    assign state      = r_state;
    assign menu_sel   = r_menu_sel;
    assign score_p1   = r_s1;
    assign score_p2   = r_s2;
    assign ball_reset = r_ball_reset;
    assign ball_run   = r_ball_run;
    assign winner     = r_winner;

endmodule
